// File: rtl/roberto_uc_pkg.sv
// Shared state encodings and index limits for the roberto control unit.
package roberto_uc_pkg;

  // TX sequencer states; the numeric codes are exported on db_estado.
  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    PREPARA        = 4'd1,
    ESPERA_SEG     = 4'd2,
    MEDE           = 4'd3,
    AGUARDA_MEDIDA = 4'd4,
    TRANSMITE      = 4'd5,
    ESPERA_TX      = 4'd6,
    PROX_CHAR      = 4'd7,
    PROX_SENSOR    = 4'd8
  } tx_state_t;

  // RX slot sequencer states; the numeric codes are exported on db_estado_rx.
  typedef enum logic [1:0] {
    R_ESPERA = 2'd0,
    R_CONTA  = 2'd1,
    R_SALTA  = 2'd2
  } rx_state_t;

  // Last char of a sensor word (3 digits + '#').
  localparam logic [1:0] ULTIMO_CHAR   = 2'd3;
  // Last of the three sensors.
  localparam logic [1:0] ULTIMO_SENSOR = 2'd2;
  // Last real servo slot; slot 3 is skipped so the RX index wraps to 0.
  localparam logic [1:0] ULTIMO_SLOT   = 2'd2;

endpackage

// File: rtl/roberto_uc_rx.sv
// RX sequencer: steers each received char into servo slots 0/1/2 and wraps.
// Handshake: pronto_recepcao is level-valid from the datapath; only its
// rising edge counts as a new char, and cont_recepcao is a one-cycle
// advance pulse for the slot counter (no back-pressure in either direction).
module roberto_uc_rx
  import roberto_uc_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       ativo,
  input  logic       pronto_recepcao,
  input  logic [1:0] Q_recepcao,
  output logic       cont_recepcao,
  output logic [1:0] db_estado_rx
);

  rx_state_t estado;
  logic      pronto_d;
  logic      evento;

  assign evento = pronto_recepcao & ~pronto_d;

  // Registered copy of pronto_recepcao for rising-edge detection.
  always_ff @(posedge clock) begin
    if (reset) pronto_d <= 1'b0;
    else       pronto_d <= pronto_recepcao;
  end

  // Slot sequencer; parked in R_ESPERA whenever the TX side is idle.
  always_ff @(posedge clock) begin
    if (reset || !ativo) begin
      estado <= R_ESPERA;
    end else begin
      case (estado)
        R_ESPERA: if (evento) estado <= R_CONTA;
        R_CONTA:  estado <= (Q_recepcao == ULTIMO_SLOT) ? R_SALTA : R_ESPERA;
        R_SALTA:  estado <= R_ESPERA;
        default:  estado <= R_ESPERA;
      endcase
    end
  end

  // Both counting states advance the slot index by one.
  assign cont_recepcao = (estado == R_CONTA) || (estado == R_SALTA);
  assign db_estado_rx  = estado;

endmodule

// File: rtl/roberto_uc.sv
// Control unit for roberto_fd: once per second triggers the sensors, waits
// out the echo window and sends 3 sensors x 4 chars; RX runs independently.
module roberto_uc
  import roberto_uc_pkg::*;
#(
  parameter int T_MEDIDA = 1_500_000,
  parameter int W_MEDIDA = 21
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       pronto_seg,
  input  logic       pronto_serial,
  input  logic       pronto_recepcao,
  input  logic [1:0] Q_2,
  input  logic [1:0] Q_3,
  input  logic [1:0] Q_recepcao,
  output logic       zera_sensor,
  output logic       zera_serial,
  output logic       zera_seg,
  output logic       zera_2,
  output logic       zera_3,
  output logic       zera_servos,
  output logic       zera_recpcao,
  output logic       cont_seg,
  output logic       cont_2,
  output logic       cont_3,
  output logic       cont_recepcao,
  output logic       medir,
  output logic       partida_tx,
  output logic [3:0] db_estado,
  output logic [1:0] db_estado_rx
);

  localparam logic [W_MEDIDA-1:0] ALVO_MEDIDA = W_MEDIDA'(T_MEDIDA - 1);

  tx_state_t           estado;
  logic [W_MEDIDA-1:0] cnt_medida;

  // TX sequencer plus echo-window counter; ligar matters only in 0 and 2.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado     <= INICIAL;
      cnt_medida <= '0;
    end else begin
      case (estado)
        INICIAL:    if (ligar) estado <= PREPARA;
        PREPARA:    estado <= ESPERA_SEG;
        ESPERA_SEG: begin
          if (!ligar)          estado <= INICIAL;
          else if (pronto_seg) estado <= MEDE;
        end
        MEDE: begin
          cnt_medida <= '0;
          estado     <= AGUARDA_MEDIDA;
        end
        AGUARDA_MEDIDA: begin
          if (cnt_medida == ALVO_MEDIDA) estado <= TRANSMITE;
          else                           cnt_medida <= cnt_medida + 1'b1;
        end
        TRANSMITE:   estado <= ESPERA_TX;
        ESPERA_TX:   if (pronto_serial) estado <= PROX_CHAR;
        PROX_CHAR:   estado <= (Q_3 == ULTIMO_CHAR) ? PROX_SENSOR : TRANSMITE;
        PROX_SENSOR: estado <= (Q_2 == ULTIMO_SENSOR) ? ESPERA_SEG : TRANSMITE;
        default:     estado <= INICIAL;
      endcase
    end
  end

  // Datapath controls decoded from the registered TX state.
  always_comb begin
    zera_sensor  = 1'b0;
    zera_serial  = 1'b0;
    zera_seg     = 1'b0;
    zera_2       = 1'b0;
    zera_3       = 1'b0;
    zera_servos  = 1'b0;
    zera_recpcao = 1'b0;
    cont_seg     = 1'b0;
    cont_2       = 1'b0;
    cont_3       = 1'b0;
    medir        = 1'b0;
    partida_tx   = 1'b0;
    case (estado)
      INICIAL: begin
        zera_sensor  = 1'b1;
        zera_serial  = 1'b1;
        zera_seg     = 1'b1;
        zera_2       = 1'b1;
        zera_3       = 1'b1;
        zera_servos  = 1'b1;
        zera_recpcao = 1'b1;
      end
      PREPARA: begin
        zera_sensor = 1'b1;
        zera_serial = 1'b1;
        zera_seg    = 1'b1;
        zera_2      = 1'b1;
        zera_3      = 1'b1;
      end
      ESPERA_SEG: cont_seg = 1'b1;
      MEDE: begin
        medir    = 1'b1;
        zera_seg = 1'b1;
      end
      TRANSMITE: partida_tx = 1'b1;
      PROX_CHAR: begin
        if (Q_3 == ULTIMO_CHAR) zera_3 = 1'b1;
        else                    cont_3 = 1'b1;
      end
      PROX_SENSOR: begin
        if (Q_2 == ULTIMO_SENSOR) zera_2 = 1'b1;
        else                      cont_2 = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estado;

  roberto_uc_rx u_rx (
    .clock           (clock),
    .reset           (reset),
    .ativo           (estado != INICIAL),
    .pronto_recepcao (pronto_recepcao),
    .Q_recepcao      (Q_recepcao),
    .cont_recepcao   (cont_recepcao),
    .db_estado_rx    (db_estado_rx)
  );

endmodule

// File: tb/tb_roberto_uc.sv
// Bench for roberto_uc with a small datapath model around it.
module tb_roberto_uc;

  localparam int T_MEDIDA   = 20;
  localparam int W_MEDIDA   = 5;
  localparam int SEG_CICLOS = 50;
  localparam int TX_CICLOS  = 10;

  logic       clock = 1'b0;
  logic       reset;
  logic       ligar;
  logic       pronto_seg;
  logic       pronto_serial;
  logic       pronto_recepcao;
  logic [1:0] Q_2, Q_3, Q_recepcao;
  logic       zera_sensor, zera_serial, zera_seg, zera_2, zera_3, zera_servos, zera_recpcao;
  logic       cont_seg, cont_2, cont_3, cont_recepcao;
  logic       medir, partida_tx;
  logic [3:0] db_estado;
  logic [1:0] db_estado_rx;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [3:0] exp_q[$];     // expected {sensor, char} of each partida_tx
  logic [1:0] rx_exp_q[$];  // expected servo register (1..3) of each received char

  int seg_cnt, tx_cnt;
  int rx_k;          // chars received since the block last left INICIAL
  int frames_done;
  int n_cont_rx;

  roberto_uc #(.T_MEDIDA(T_MEDIDA), .W_MEDIDA(W_MEDIDA)) dut (
    .clock(clock), .reset(reset), .ligar(ligar),
    .pronto_seg(pronto_seg), .pronto_serial(pronto_serial), .pronto_recepcao(pronto_recepcao),
    .Q_2(Q_2), .Q_3(Q_3), .Q_recepcao(Q_recepcao),
    .zera_sensor(zera_sensor), .zera_serial(zera_serial), .zera_seg(zera_seg),
    .zera_2(zera_2), .zera_3(zera_3), .zera_servos(zera_servos), .zera_recpcao(zera_recpcao),
    .cont_seg(cont_seg), .cont_2(cont_2), .cont_3(cont_3), .cont_recepcao(cont_recepcao),
    .medir(medir), .partida_tx(partida_tx),
    .db_estado(db_estado), .db_estado_rx(db_estado_rx)
  );

  // Clock and cycle counter.
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Datapath model: 1 s counter, TX char timer, index counters.
  always @(posedge clock) begin
    if (reset) begin
      seg_cnt <= 0; tx_cnt <= 0;
      Q_2 <= 2'd0; Q_3 <= 2'd0; Q_recepcao <= 2'd0;
    end else begin
      if (zera_seg) seg_cnt <= 0;
      else if (cont_seg && seg_cnt < SEG_CICLOS) seg_cnt <= seg_cnt + 1;
      if (partida_tx) tx_cnt <= TX_CICLOS;
      else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
      if (zera_2) Q_2 <= 2'd0; else if (cont_2) Q_2 <= Q_2 + 2'd1;
      if (zera_3) Q_3 <= 2'd0; else if (cont_3) Q_3 <= Q_3 + 2'd1;
      if (zera_recpcao) Q_recepcao <= 2'd0; else if (cont_recepcao) Q_recepcao <= Q_recepcao + 2'd1;
    end
  end
  assign pronto_seg    = (seg_cnt == SEG_CICLOS);
  assign pronto_serial = (tx_cnt == 1);

  task automatic check(input string nome, input int actual, input int expected);
    n_chk++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nome, actual, expected, cyc);
    end
  endtask

  // TX scoreboard: medir loads the expected frame, each partida_tx pops one entry.
  logic [3:0] prev_estado;
  logic       prev_pronto_seg;
  logic       first_pending;
  int         first_due, f_part, f_c3, f_c2;
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      first_pending = 1'b0;
      f_part = 0; f_c3 = 0; f_c2 = 0;
      prev_estado = 4'd0; prev_pronto_seg = 1'b0;
    end else begin
      if (medir) begin
        check("medir_after_pronto_seg", int'(prev_pronto_seg), 1);
        check("frame_queue_empty_at_medir", exp_q.size(), 0);
        for (int s = 0; s < 3; s++)
          for (int c = 0; c < 4; c++)
            exp_q.push_back(4'((s << 2) | c));
        first_due     = cyc + T_MEDIDA + 1;
        first_pending = 1'b1;
      end
      if (partida_tx) begin
        if (exp_q.size() == 0) begin
          check("unexpected_partida_tx", 1, 0);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          check("partida_char_index", int'({Q_2, Q_3}), int'(e));
        end
        if (first_pending) check("echo_window_latency", cyc, first_due);
        first_pending = 1'b0;
        f_part++;
      end
      if (cont_3) f_c3++;
      if (cont_2) f_c2++;
      if (db_estado == 4'd2 && prev_estado == 4'd8) begin
        check("frame_partida_count", f_part, 12);
        check("frame_cont_3_count", f_c3, 9);
        check("frame_cont_2_count", f_c2, 2);
        f_part = 0; f_c3 = 0; f_c2 = 0;
        frames_done++;
      end
      prev_estado     = db_estado;
      prev_pronto_seg = pronto_seg;
    end
  end

  // RX scoreboard: each rising pronto_recepcao must load the predicted register.
  logic prev_prx;
  always @(negedge clock) begin
    if (reset) begin
      prev_prx = 1'b0;
      rx_exp_q.delete();
    end else begin
      if (cont_recepcao) n_cont_rx++;
      if (pronto_recepcao && !prev_prx) begin
        if (rx_exp_q.size() == 0) check("unexpected_rx_char", 1, 0);
        else check("rx_servo_register", int'(Q_recepcao) + 1, int'(rx_exp_q.pop_front()));
      end
      prev_prx = pronto_recepcao;
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic wait_estado(input logic [3:0] alvo, input int budget, input string nome);
    int n = 0;
    while (db_estado !== alvo && n < budget) begin tick(); n++; end
    check(nome, int'(db_estado), int'(alvo));
  endtask

  // Raise pronto_recepcao now and record which servo register it should land in.
  task automatic rx_raise();
    pronto_recepcao = 1'b1;
    rx_exp_q.push_back(2'((rx_k % 3) + 1));
    rx_k++;
  endtask

  task automatic reset_dut();
    reset = 1'b1; ligar = 1'b0; pronto_recepcao = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    rx_k  = 0;
  endtask

  // Stimulus.
  initial begin
    int slots_3, cont_base, frames_base, n;
    logic [16:0] vec, idle_vec;
    frames_done = 0; n_cont_rx = 0; rx_k = 0;
    reset_dut();

    // Idle: parked in INICIAL with every clear asserted.
    check("reset_db_estado", int'(db_estado), 0);
    check("reset_db_estado_rx", int'(db_estado_rx), 0);
    idle_vec = {7'h7F, 10'd0};
    repeat (100) begin
      @(negedge clock);
      vec = {zera_sensor, zera_serial, zera_seg, zera_2, zera_3, zera_servos, zera_recpcao,
             cont_seg, cont_2, cont_3, cont_recepcao, medir, partida_tx, db_estado};
      check("idle_outputs", int'(vec), int'(idle_vec));
    end

    // Run; RX slot test while waiting for the first second to elapse.
    tick();
    ligar = 1'b1;
    repeat (5) tick();
    cont_base = n_cont_rx;
    slots_3 = 0;
    for (int i = 0; i < 4; i++) begin
      if ((rx_k % 3) + 1 == 3) slots_3++;
      rx_raise();
      tick();
      pronto_recepcao = 1'b0;
      repeat (18 + $urandom_range(0, 3)) tick();
    end
    check("rx_index_after_4_chars", int'(Q_recepcao), 1);
    check("rx_cont_recepcao_total", n_cont_rx - cont_base, 4 + slots_3);

    // Two full frames, back in ESPERA_SEG between them.
    n = 0;
    while (frames_done < 2 && n < 2000) begin tick(); n++; end
    check("two_frames_completed", frames_done, 2);
    check("db_estado_after_frame", int'(db_estado), 2);

    // pronto_serial and pronto_recepcao in the same cycle.
    n = 0;
    while (!(db_estado == 4'd6 && tx_cnt == 1) && n < 1000) begin tick(); n++; end
    check("coincident_sync", int'(db_estado == 4'd6 && tx_cnt == 1), 1);
    rx_raise();
    tick();
    pronto_recepcao = 1'b0;
    check("coincident_tx_prox_char", int'(db_estado), 7);
    check("coincident_rx_conta", int'(db_estado_rx), 1);

    // Reset while waiting on a TX char.
    wait_estado(4'd6, 1000, "reach_espera_tx_for_reset");
    repeat ($urandom_range(0, 4)) tick();
    reset = 1'b1; ligar = 1'b0;
    tick();
    check("reset_mid_frame_db_estado", int'(db_estado), 0);
    check("reset_mid_frame_partida", int'(partida_tx), 0);
    check("reset_mid_frame_medir", int'(medir), 0);
    reset = 1'b0;
    rx_k  = 0;
    n = 0;
    repeat (100) begin @(negedge clock); if (partida_tx || medir) n++; end
    check("no_activity_while_parked", n, 0);

    // ligar dropped mid-frame: the frame finishes, then back to INICIAL.
    tick();
    ligar = 1'b1;
    wait_estado(4'd6, 1000, "reach_espera_tx_for_ligar");
    frames_base = frames_done;
    ligar = 1'b0;
    wait_estado(4'd0, 1000, "return_to_inicial");
    check("frame_completed_after_ligar_low", frames_done - frames_base, 1);
    check("no_pending_chars", exp_q.size(), 0);
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
